// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin front end that lets several requesters share one combinational
// 16-bit adder/flag ALU. A winner's operands are registered onto the ALU inputs.
// The sum and flags are captured one cycle later and returned over a valid/ready port.
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NREQ-1:0]     i_req_valid,
    input  logic [NREQ*W-1:0]   i_req_x,
    input  logic [NREQ*W-1:0]   i_req_y,
    output logic [NREQ-1:0]     o_req_ready,
    output logic [W-1:0]        o_alu_x,
    output logic [W-1:0]        o_alu_y,
    input  logic [W-1:0]        i_alu_z,
    input  logic [4:0]          i_alu_flags,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [IDW-1:0]      o_rsp_id,
    output logic [W-1:0]        o_rsp_z,
    output logic [4:0]          o_rsp_flags,
    output logic                o_busy,
    output logic [15:0]         o_op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [W-1:0]    r_alu_x;
    logic [W-1:0]    r_alu_y;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_z;
    logic [4:0]      r_rsp_flags;
    logic            r_rsp_valid;
    logic [15:0]     r_op_count;

    logic            w_any;
    logic [IDW-1:0]  w_grant_idx;
    logic [IDW-1:0]  w_next_ptr;
    logic [W-1:0]    w_sel_x;
    logic [W-1:0]    w_sel_y;

    // Round-robin search: first pending requester at or after the pointer, wrapping.
    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = '0;
        w_sel_x     = '0;
        w_sel_y     = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_any && i_req_valid[idx]) begin
                w_any       = 1'b1;
                w_grant_idx = IDW'(idx);
                w_sel_x     = i_req_x[idx*W +: W];
                w_sel_y     = i_req_y[idx*W +: W];
            end
        end
        w_next_ptr = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grant leaves IDLE, one settle cycle, then wait for the consumer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (i_rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs: grant is combinational in IDLE and suppressed while reset is held.
    always_comb begin
        o_req_ready = '0;
        if (r_state == S_IDLE && i_rst_n && w_any) begin
            o_req_ready = NREQ'(1) << w_grant_idx;
        end
        o_busy = (r_state != S_IDLE);
    end

    // Datapath registers: operand capture on grant, result capture after settling.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr    <= '0;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_rsp_id    <= '0;
            r_rsp_z     <= '0;
            r_rsp_flags <= '0;
            r_rsp_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_alu_x  <= w_sel_x;
                        r_alu_y  <= w_sel_y;
                        r_rsp_id <= w_grant_idx;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                S_EXEC: begin
                    r_rsp_z     <= i_alu_z;
                    r_rsp_flags <= i_alu_flags;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (r_rsp_valid && i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_op_count != 16'hFFFF) begin
                            r_op_count <= r_op_count + 16'd1;
                        end
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_alu_x     = r_alu_x;
    assign o_alu_y     = r_alu_y;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_z     = r_rsp_z;
    assign o_rsp_flags = r_rsp_flags;
    assign o_rsp_valid = r_rsp_valid;
    assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Scoreboard bench: grants seen on req_ready push an expected response computed
// from the requester's operands; a monitor pops and compares on each handshake.
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk;
    logic              rstN;
    logic [NREQ-1:0]   reqValid;
    logic [15:0]       reqX [NREQ];
    logic [15:0]       reqY [NREQ];
    logic [NREQ*W-1:0] reqXBus;
    logic [NREQ*W-1:0] reqYBus;
    logic [NREQ-1:0]   reqReady;
    logic [15:0]       aluX;
    logic [15:0]       aluY;
    logic [15:0]       aluZ;
    logic [4:0]        aluFlags;
    logic              rspValid;
    logic              rspReady;
    logic [1:0]        rspId;
    logic [15:0]       rspZ;
    logic [4:0]        rspFlags;
    logic              busy;
    logic [15:0]       opCount;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rspCount = 0;
    int lastHsCyc = 0;
    logic [1:0]  lastId;
    logic [15:0] lastZ;
    logic [4:0]  lastFlags;

    logic [22:0] expQ [$];
    int          grantLog [$];
    int          grantCycLog [$];
    bit          inflight = 0;
    int          rrPtr = 0;
    int          grantCyc = 0;
    logic [15:0] expCount = 16'd0;
    bit          pendInc = 0;
    bit          prevHold = 0;
    logic [22:0] prevRsp;

    alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req_valid (reqValid),
        .i_req_x     (reqXBus),
        .i_req_y     (reqYBus),
        .o_req_ready (reqReady),
        .o_alu_x     (aluX),
        .o_alu_y     (aluY),
        .i_alu_z     (aluZ),
        .i_alu_flags (aluFlags),
        .o_rsp_valid (rspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_id    (rspId),
        .o_rsp_z     (rspZ),
        .o_rsp_flags (rspFlags),
        .o_busy      (busy),
        .o_op_count  (opCount)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack per-requester operands onto the flat buses.
    always_comb begin
        reqXBus = '0;
        reqYBus = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqXBus[i*W +: W] = reqX[i];
            reqYBus[i*W +: W] = reqY[i];
        end
    end

    // Reference result from integer arithmetic: {id, sum, {ovf, parity, carry, zero, sign}}.
    function automatic logic [22:0] refOp(input int id, input logic [15:0] x, input logic [15:0] y);
        int unsigned usum;
        int          ssum;
        logic [15:0] z;
        logic [4:0]  f;
        usum = int'(x) + int'(y);
        ssum = int'($signed(x)) + int'($signed(y));
        z    = usum[15:0];
        f[4] = (ssum > 32767) || (ssum < -32768);
        f[3] = ($countones(z) % 2) == 0;
        f[2] = usum > 32'd65535;
        f[1] = (z == 16'd0);
        f[0] = z[15];
        return {2'(id), z, f};
    endfunction

    // External ALU behaves like the reference arithmetic.
    always_comb begin
        logic [22:0] r;
        r        = refOp(0, aluX, aluY);
        aluZ     = r[20:5];
        aluFlags = r[4:0];
    end

    function automatic int pickGrant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        bit          wasInflight;
        int          g;
        logic [3:0]  expReady;
        logic [22:0] cur;
        logic [22:0] exp;
        cyc++;
        if (!rstN) begin
            checkOutput("reset_ctrl", 64'({reqReady, rspValid, busy, opCount, rspId}), 64'd0);
            checkOutput("reset_data", 64'({aluX, aluY, rspZ, rspFlags}), 64'd0);
            expQ.delete();
            grantLog.delete();
            grantCycLog.delete();
            inflight = 0;
            rrPtr    = 0;
            expCount = 16'd0;
            pendInc  = 0;
            prevHold = 0;
        end else begin
            if (pendInc) begin
                if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
                pendInc = 0;
            end
            wasInflight = inflight;
            checkOutput("op_count", 64'(opCount), 64'(expCount));
            checkOutput("busy", 64'(busy), 64'(wasInflight));
            checkOutput("rsp_valid_timing", 64'(rspValid), 64'(wasInflight && (cyc - grantCyc) >= 2));
            if (!wasInflight) begin
                g = pickGrant(reqValid, rrPtr);
                expReady = (g >= 0) ? (4'b0001 << g) : 4'b0000;
                checkOutput("req_ready", 64'(reqReady), 64'(expReady));
                if (g >= 0) begin
                    expQ.push_back(refOp(g, reqX[g], reqY[g]));
                    inflight = 1;
                    rrPtr    = (g + 1) % NREQ;
                    grantCyc = cyc;
                    grantLog.push_back(g);
                    grantCycLog.push_back(cyc);
                end
            end else begin
                checkOutput("req_ready_busy", 64'(reqReady), 64'd0);
            end
            if (wasInflight && rspValid) begin
                cur = {rspId, rspZ, rspFlags};
                if (prevHold) checkOutput("rsp_stable", 64'(cur), 64'(prevRsp));
                if (rspReady) begin
                    if (expQ.size() == 0) begin
                        checkOutput("rsp_unexpected", 64'(cur), 64'h7FFFFF_FFFF);
                    end else begin
                        exp = expQ.pop_front();
                        checkOutput("rsp_data", 64'(cur), 64'(exp));
                    end
                    lastId    = rspId;
                    lastZ     = rspZ;
                    lastFlags = rspFlags;
                    lastHsCyc = cyc;
                    rspCount++;
                    pendInc  = 1;
                    inflight = 0;
                    prevHold = 0;
                end else begin
                    prevHold = 1;
                    prevRsp  = cur;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic ready);
        reqValid = valid;
        rspReady = ready;
    endtask

    task automatic waitGrant(input int idx, input string tag);
        int n;
        bit found;
        n = 0;
        found = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (reqReady[idx]) found = 1;
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_grant_wait"}, 64'(found), 64'd1);
    endtask

    task automatic waitResp(input int target, input string tag);
        int n;
        n = 0;
        while (rspCount < target && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_resp_wait"}, 64'(rspCount >= target), 64'd1);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 rstN = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
    endtask

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Directed and random stimulus.
    initial begin
        int target;
        int expOrder [6];
        int hsBefore;
        expOrder = '{0, 1, 2, 3, 0, 1};
        rstN = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            reqX[i] = '0;
            reqY[i] = '0;
        end
        applyStimulus(4'b0000, 1'b0);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        $display("[TB] T1 single op");
        reqX[0] = 16'h7FFF;
        reqY[0] = 16'h0001;
        target = rspCount + 1;
        applyStimulus(4'b0001, 1'b1);
        waitGrant(0, "T1");
        reqValid = 4'b0000;
        waitResp(target, "T1");
        checkOutput("T1_id", 64'(lastId), 64'd0);
        checkOutput("T1_z", 64'(lastZ), 64'h8000);
        checkOutput("T1_flags", 64'(lastFlags), 64'b10001);

        $display("[TB] T2 carry and zero");
        reqX[2] = 16'hFFFF;
        reqY[2] = 16'h0001;
        target = rspCount + 1;
        applyStimulus(4'b0100, 1'b1);
        waitGrant(2, "T2");
        reqValid = 4'b0000;
        waitResp(target, "T2");
        checkOutput("T2_id", 64'(lastId), 64'd2);
        checkOutput("T2_z", 64'(lastZ), 64'h0000);
        checkOutput("T2_flags", 64'(lastFlags), 64'b01110);

        $display("[TB] T3 round robin");
        pulseReset();
        for (int i = 0; i < NREQ; i++) begin
            reqX[i] = 16'($urandom);
            reqY[i] = 16'($urandom);
        end
        target = rspCount + 6;
        applyStimulus(4'b1111, 1'b1);
        waitResp(target, "T3");
        reqValid = 4'b0000;
        checkOutput("T3_grants", 64'(grantLog.size() >= 6), 64'd1);
        if (grantLog.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput("T3_order", 64'(grantLog[i]), 64'(expOrder[i]));
            end
            for (int i = 1; i < 6; i++) begin
                checkOutput("T3_interval", 64'(grantCycLog[i] - grantCycLog[i-1]), 64'd3);
            end
        end
        @(negedge clk);
        checkOutput("T3_count", 64'(opCount), 64'd6);

        $display("[TB] T4 backpressure");
        @(posedge clk);
        #1;
        target = rspCount + 1;
        applyStimulus(4'b0001, 1'b0);
        waitGrant(0, "T4");
        reqValid = 4'b0010;
        repeat (2) @(negedge clk);
        checkOutput("T4_rsp_valid", 64'(rspValid), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rspReady = 1'b1;
        waitResp(target, "T4");
        hsBefore = lastHsCyc;
        waitGrant(1, "T4b");
        reqValid = 4'b0000;
        checkOutput("T4_grant_after_hs", 64'(grantCycLog[grantCycLog.size()-1] - hsBefore), 64'd1);
        waitResp(rspCount + 1, "T4b");

        $display("[TB] T5 reset mid-op");
        applyStimulus(4'b0100, 1'b1);
        waitGrant(2, "T5");
        reqValid = 4'b1010;
        rstN = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rstN = 1'b1;
        target = rspCount + 1;
        waitGrant(1, "T5b");
        reqValid = 4'b0000;
        checkOutput("T5_first_grant", 64'(grantLog.size() > 0 ? grantLog[0] : -1), 64'd1);
        waitResp(target, "T5");

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                reqX[i] = pickOperand();
                reqY[i] = pickOperand();
            end
            applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        applyStimulus(4'b0000, 1'b1);
        repeat (12) @(posedge clk);
        #1;

        $display("[TB] T6 saturation");
        expCount = 16'hFFFE;
        force dut.r_op_count = 16'hFFFE;
        @(posedge clk);
        #1 release dut.r_op_count;
        target = rspCount + 3;
        applyStimulus(4'b1111, 1'b1);
        waitResp(target, "T6");
        reqValid = 4'b0000;
        @(negedge clk);
        checkOutput("T6_saturate", 64'(opCount), 64'hFFFF);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
